// File: rtl/rom_port_arbiter_if.sv
// Bundle of the requester handshake, response handshake and ROM drive signals
// shared between rom_port_arbiter and its surroundings.
interface rom_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int WIDTHAD = 8,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*WIDTHAD-1:0] req_addr;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [WIDTH-1:0]           rsp_data;
  logic [IDW-1:0]             rsp_id;
  logic                       rom_clken;
  logic                       rom_read_en;
  logic [WIDTHAD-1:0]         rom_address;
  logic [WIDTH-1:0]           rom_read_data;

  // Arbiter side.
  modport slave (
    input  req_valid, req_addr, rsp_ready, rom_read_data,
    output req_ready, rsp_valid, rsp_data, rsp_id,
           rom_clken, rom_read_en, rom_address
  );

  // Requesters, response consumer and ROM side.
  modport master (
    output req_valid, req_addr, rsp_ready, rom_read_data,
    input  req_ready, rsp_valid, rsp_data, rsp_id,
           rom_clken, rom_read_en, rom_address
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one single-port ROM among NUM_REQ requesters.
// A tag shift register follows each read through the ROM's fixed latency so
// the returned word carries the issuing requester's ID. Response backpressure
// freezes the ROM and the tag pipeline together through rom_clken.
module rom_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int WIDTHAD = 8,
  parameter int LATENCY = 1,
  parameter int IDW     = 2
) (
  input  logic              clk,
  input  logic              reset,
  rom_port_arbiter_if.slave bus
);

  logic               w_stall;
  logic               w_grant_vld;
  logic [IDW-1:0]     w_grant_idx;
  int                 w_dist;
  int                 w_best;
  logic [WIDTH-1:0]   w_rsp_data;

  logic [IDW-1:0]     r_last_grant;
  logic               r_tag_vld [LATENCY];
  logic [IDW-1:0]     r_tag_id  [LATENCY];

  // A presented response that the consumer refuses freezes everything.
  assign w_stall       = r_tag_vld[LATENCY-1] & ~bus.rsp_ready;
  assign bus.rom_clken = ~w_stall;

  // Round-robin search: the valid requester closest after last_grant wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_best      = NUM_REQ;
    w_dist      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - 1 - int'(r_last_grant)) % NUM_REQ;
      if (bus.req_valid[i] && !w_stall && (w_dist < w_best)) begin
        w_best      = w_dist;
        w_grant_vld = 1'b1;
        w_grant_idx = IDW'(i);
      end
    end
  end

  // One-hot grant and address mux toward the ROM.
  always_comb begin
    bus.req_ready   = '0;
    bus.rom_address = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_vld && (w_grant_idx == IDW'(i))) begin
        bus.req_ready[i] = 1'b1;
        bus.rom_address  = bus.req_addr[i*WIDTHAD +: WIDTHAD];
      end
    end
  end

  assign bus.rom_read_en = w_grant_vld;

  // Remember the last accepted grant; reset value gives requester 0 priority.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!reset) begin
      r_last_grant <= IDW'(NUM_REQ - 1);
    end else if (!w_stall && w_grant_vld) begin
      r_last_grant <= w_grant_idx;
    end
  end

  // Tag pipeline mirroring the ROM's read latency; holds while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the tag array is a handful of flops, not a RAM, so every stage
      // is reset; clearing valids discards reads in flight and clearing IDs
      // keeps rsp_id at 0 during reset.
      for (int k = 0; k < LATENCY; k++) begin
        r_tag_vld[k] <= 1'b0;
        r_tag_id[k]  <= '0;
      end
    end else if (!w_stall) begin
      r_tag_vld[0] <= w_grant_vld;
      r_tag_id[0]  <= w_grant_idx;
      for (int k = 1; k < LATENCY; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end
    end
  end

  // Response: last tag stage plus ROM data passed straight through.
  assign w_rsp_data    = bus.rom_read_data;
  assign bus.rsp_data  = w_rsp_data;
  assign bus.rsp_valid = r_tag_vld[LATENCY-1];
  assign bus.rsp_id    = r_tag_id[LATENCY-1];

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Testbench for rom_port_arbiter: four instances with LATENCY 1..4 share the
// same stimulus, each with its own ROM model; `sel` picks the one observed.
module tb_rom_port_arbiter;
  localparam int N = 4;

  typedef struct {
    int         id;
    logic [7:0] addr;
    int         age;
  } rd_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_addr;
  logic           rsp_ready;
  logic [7:0]     rom [256];

  int n_cmp = 0;
  int n_err = 0;
  int sel   = 0;

  logic [N-1:0] ob_ready [4];
  logic         ob_rv    [4];
  logic         ob_clken [4];
  logic         ob_rden  [4];
  logic [7:0]   ob_addr  [4];
  logic [7:0]   ob_data  [4];
  logic [1:0]   ob_id    [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = g + 1;
    logic [7:0] pipe [L];

    rom_port_arbiter_if #(.NUM_REQ(N), .WIDTH(8), .WIDTHAD(8), .IDW(2)) bus ();

    rom_port_arbiter #(
      .NUM_REQ(N), .WIDTH(8), .WIDTHAD(8), .LATENCY(L), .IDW(2)
    ) u_dut (
      .clk  (clk),
      .reset(rst_n),
      .bus  (bus.slave)
    );

    assign bus.req_valid     = req_valid;
    assign bus.req_addr      = req_addr;
    assign bus.rsp_ready     = rsp_ready;
    assign bus.rom_read_data = pipe[L-1];

    // ROM model: L enabled edges from address to data, frozen by clken.
    always @(posedge clk) begin
      if (bus.rom_clken) begin
        pipe[0] <= rom[bus.rom_address];
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
      end
    end

    assign ob_ready[g] = bus.req_ready;
    assign ob_rv[g]    = bus.rsp_valid;
    assign ob_clken[g] = bus.rom_clken;
    assign ob_rden[g]  = bus.rom_read_en;
    assign ob_addr[g]  = bus.rom_address;
    assign ob_data[g]  = bus.rsp_data;
    assign ob_id[g]    = bus.rsp_id;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (ob_rv[d] !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid inst%0d: got %b expected 0", d, ob_rv[d]); end
      n_cmp++; if (ob_id[d] !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id inst%0d: got %0d expected 0", d, ob_id[d]); end
      n_cmp++; if (ob_ready[d] !== 4'b0) begin n_err++; $display("FAIL reset_req_ready inst%0d: got %b expected 0000", d, ob_ready[d]); end
      n_cmp++; if (ob_rden[d] !== 1'b0) begin n_err++; $display("FAIL reset_read_en inst%0d: got %b expected 0", d, ob_rden[d]); end
      n_cmp++; if (ob_addr[d] !== 8'h00) begin n_err++; $display("FAIL reset_address inst%0d: got %h expected 00", d, ob_addr[d]); end
      n_cmp++; if (ob_clken[d] !== 1'b1) begin n_err++; $display("FAIL reset_clken inst%0d: got %b expected 1", d, ob_clken[d]); end
    end
    tick();
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        n_cmp++; if (ob_rden[d] !== 1'b0) begin n_err++; $display("FAIL idle_read_en inst%0d: got %b expected 0", d, ob_rden[d]); end
        n_cmp++; if (ob_rv[d] !== 1'b0) begin n_err++; $display("FAIL idle_rsp_valid inst%0d: got %b expected 0", d, ob_rv[d]); end
      end
      tick();
    end
  endtask

  task automatic test_single_read();
    sel = 0;
    do_reset();
    req_valid = 4'b0100;
    req_addr[2*8 +: 8] = 8'h10;
    @(negedge clk);
    n_cmp++; if (ob_ready[sel] !== 4'b0100) begin n_err++; $display("FAIL single_grant: got %b expected 0100", ob_ready[sel]); end
    n_cmp++; if (ob_addr[sel] !== 8'h10) begin n_err++; $display("FAIL single_address: got %h expected 10", ob_addr[sel]); end
    n_cmp++; if (ob_rden[sel] !== 1'b1) begin n_err++; $display("FAIL single_read_en: got %b expected 1", ob_rden[sel]); end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_cmp++; if (ob_rv[sel] !== 1'b1) begin n_err++; $display("FAIL single_rsp_valid: got %b expected 1", ob_rv[sel]); end
    n_cmp++; if (ob_data[sel] !== 8'hA5) begin n_err++; $display("FAIL single_rsp_data: got %h expected a5", ob_data[sel]); end
    n_cmp++; if (ob_id[sel] !== 2'd2) begin n_err++; $display("FAIL single_rsp_id: got %0d expected 2", ob_id[sel]); end
    tick();
    @(negedge clk);
    n_cmp++; if (ob_rv[sel] !== 1'b0) begin n_err++; $display("FAIL single_rsp_done: got %b expected 0", ob_rv[sel]); end
    tick();
  endtask

  task automatic test_round_robin();
    sel = 0;
    do_reset();
    req_valid = '1;
    for (int i = 0; i < N; i++) req_addr[i*8 +: 8] = 8'(8'h40 + i);
    for (int c = 0; c < 9; c++) begin
      logic [N-1:0] exp_rdy;
      int           pid;
      if (c == 8) req_valid = '0;
      exp_rdy = '0;
      if (c < 8) exp_rdy[c % N] = 1'b1;
      @(negedge clk);
      n_cmp++; if (ob_ready[sel] !== exp_rdy) begin n_err++; $display("FAIL rr_grant c%0d: got %b expected %b", c, ob_ready[sel], exp_rdy); end
      if (c > 0) begin
        pid = (c - 1) % N;
        n_cmp++; if (ob_rv[sel] !== 1'b1) begin n_err++; $display("FAIL rr_rsp_valid c%0d: got %b expected 1", c, ob_rv[sel]); end
        n_cmp++; if (ob_id[sel] !== 2'(pid)) begin n_err++; $display("FAIL rr_rsp_id c%0d: got %0d expected %0d", c, ob_id[sel], pid); end
        n_cmp++; if (ob_data[sel] !== rom[64 + pid]) begin n_err++; $display("FAIL rr_rsp_data c%0d: got %h expected %h", c, ob_data[sel], rom[64 + pid]); end
      end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (ob_rv[sel] !== 1'b0) begin n_err++; $display("FAIL rr_drained: got %b expected 0", ob_rv[sel]); end
    tick();
  endtask

  task automatic test_backpressure();
    sel = 2;
    do_reset();
    for (int i = 0; i < N; i++) req_addr[i*8 +: 8] = 8'(8'h40 + i);
    for (int c = 0; c < 12; c++) begin
      logic [N-1:0] exp_rdy;
      exp_rdy = '0;
      if (c < 8) req_valid = '1; else req_valid = '0;
      rsp_ready = !((c == 1) || (c >= 3 && c <= 7));
      @(negedge clk);
      if (c < 3) begin
        exp_rdy[c] = 1'b1;
        n_cmp++; if (ob_ready[sel] !== exp_rdy) begin n_err++; $display("FAIL bp_grant c%0d: got %b expected %b", c, ob_ready[sel], exp_rdy); end
        n_cmp++; if (ob_clken[sel] !== 1'b1) begin n_err++; $display("FAIL bp_clken_idle c%0d: got %b expected 1", c, ob_clken[sel]); end
        n_cmp++; if (ob_rv[sel] !== 1'b0) begin n_err++; $display("FAIL bp_early_valid c%0d: got %b expected 0", c, ob_rv[sel]); end
      end else if (c < 8) begin
        n_cmp++; if (ob_clken[sel] !== 1'b0) begin n_err++; $display("FAIL bp_clken_stall c%0d: got %b expected 0", c, ob_clken[sel]); end
        n_cmp++; if (ob_ready[sel] !== 4'b0) begin n_err++; $display("FAIL bp_ready_stall c%0d: got %b expected 0000", c, ob_ready[sel]); end
        n_cmp++; if (ob_rv[sel] !== 1'b1) begin n_err++; $display("FAIL bp_valid_stall c%0d: got %b expected 1", c, ob_rv[sel]); end
        n_cmp++; if (ob_id[sel] !== 2'd0) begin n_err++; $display("FAIL bp_id_stall c%0d: got %0d expected 0", c, ob_id[sel]); end
        n_cmp++; if (ob_data[sel] !== rom[64]) begin n_err++; $display("FAIL bp_data_stall c%0d: got %h expected %h", c, ob_data[sel], rom[64]); end
      end else if (c < 11) begin
        n_cmp++; if (ob_rv[sel] !== 1'b1) begin n_err++; $display("FAIL bp_drain_valid c%0d: got %b expected 1", c, ob_rv[sel]); end
        n_cmp++; if (ob_id[sel] !== 2'(c - 8)) begin n_err++; $display("FAIL bp_drain_id c%0d: got %0d expected %0d", c, ob_id[sel], c - 8); end
        n_cmp++; if (ob_data[sel] !== rom[64 + c - 8]) begin n_err++; $display("FAIL bp_drain_data c%0d: got %h expected %h", c, ob_data[sel], rom[64 + c - 8]); end
      end else begin
        n_cmp++; if (ob_rv[sel] !== 1'b0) begin n_err++; $display("FAIL bp_no_extra c%0d: got %b expected 0", c, ob_rv[sel]); end
      end
      tick();
    end
    rsp_ready = 1'b1;
  endtask

  task automatic test_reset_mid_flight();
    sel = 1;
    do_reset();
    req_valid = 4'b0010;
    req_addr[1*8 +: 8] = 8'h41;
    @(negedge clk);
    n_cmp++; if (ob_ready[sel] !== 4'b0010) begin n_err++; $display("FAIL rmf_grant: got %b expected 0010", ob_ready[sel]); end
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_cmp++; if (ob_rv[sel] !== 1'b0) begin n_err++; $display("FAIL rmf_no_rsp: got %b expected 0", ob_rv[sel]); end
      tick();
    end
    req_valid = '1;
    @(negedge clk);
    n_cmp++; if (ob_ready[sel] !== 4'b0001) begin n_err++; $display("FAIL rmf_first_grant: got %b expected 0001", ob_ready[sel]); end
    tick();
    req_valid = '0;
  endtask

  // Behavioural model: queue of outstanding reads aged by enabled edges.
  task automatic test_random(input int lat, input int ncyc);
    rd_t          q[$];
    int           last;
    int           wt [N];
    int           gnt;
    int           p;
    logic         exp_rv;
    logic         stall;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] rv_now;
    logic [7:0]   gaddr;
    sel = lat - 1;
    do_reset();
    last = N - 1;
    foreach (wt[i]) wt[i] = 0;
    for (int c = 0; c < ncyc; c++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) req_addr[i*8 +: 8] = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rv_now = req_valid;
      @(negedge clk);
      exp_rv = (q.size() > 0) && (q[0].age == lat);
      stall  = exp_rv && !rsp_ready;
      gnt = -1;
      if (!stall) begin
        for (int k = 1; k <= N; k++) begin
          p = (last + k) % N;
          if (gnt < 0 && rv_now[p[1:0]]) gnt = p;
        end
      end
      exp_rdy = '0;
      gaddr   = 8'h00;
      if (gnt >= 0) begin
        exp_rdy[gnt[1:0]] = 1'b1;
        gaddr = req_addr[gnt*8 +: 8];
      end
      n_cmp++; if (ob_ready[sel] !== exp_rdy) begin n_err++; $display("FAIL rand_L%0d_grant c%0d: got %b expected %b", lat, c, ob_ready[sel], exp_rdy); end
      n_cmp++; if (ob_clken[sel] !== !stall) begin n_err++; $display("FAIL rand_L%0d_clken c%0d: got %b expected %b", lat, c, ob_clken[sel], !stall); end
      n_cmp++; if (ob_addr[sel] !== gaddr) begin n_err++; $display("FAIL rand_L%0d_address c%0d: got %h expected %h", lat, c, ob_addr[sel], gaddr); end
      n_cmp++; if (ob_rv[sel] !== exp_rv) begin n_err++; $display("FAIL rand_L%0d_rsp_valid c%0d: got %b expected %b", lat, c, ob_rv[sel], exp_rv); end
      if (exp_rv) begin
        n_cmp++; if (ob_id[sel] !== 2'(q[0].id)) begin n_err++; $display("FAIL rand_L%0d_rsp_id c%0d: got %0d expected %0d", lat, c, ob_id[sel], q[0].id); end
        n_cmp++; if (ob_data[sel] !== rom[q[0].addr]) begin n_err++; $display("FAIL rand_L%0d_rsp_data c%0d: got %h expected %h", lat, c, ob_data[sel], rom[q[0].addr]); end
      end
      // Fairness: grants seen by a requester that keeps waiting.
      for (int i = 0; i < N; i++) begin
        if (!rv_now[i] || gnt == i) wt[i] = 0;
        else if (gnt >= 0) wt[i]++;
        n_cmp++; if (wt[i] > N) begin n_err++; $display("FAIL rand_L%0d_starve c%0d: requester %0d waited %0d grants, limit %0d", lat, c, i, wt[i], N); end
      end
      @(posedge clk);
      if (!stall) begin
        if (exp_rv) void'(q.pop_front());
        foreach (q[j]) q[j].age++;
        if (gnt >= 0) begin
          q.push_back('{id: gnt, addr: gaddr, age: 1});
          last = gnt;
        end
      end
      #1;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 8'(a * 37 + 11);
    rom[16] = 8'hA5;
    for (int i = 0; i < N; i++) rom[64 + i] = 8'(8'hC0 | i);

    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_reset_mid_flight();
    test_random(1, 3400);
    test_random(2, 3400);
    test_random(4, 3400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
